pe_column_sequencer: RTL and testbench
======================================

Name: pe_column_sequencer

Overview:
Autonomous command sequencer for the 3-PE column plus accumulator custom-instruction datapath. Replaces per-word CPU custom-instruction issue: it consumes a word stream (3 kernel weights, then samples) and drives the datapath command port (start/n/dataa). It runs a stride-1 1-D convolution over a 3-sample sliding window and returns one accumulated result per window on a valid/ready stream. Sits between the Nios-side DMA/stream adapter and the PE column instruction block.

Parameters:
DataWidth, 32, width of weights, samples, bias and results
CountWidth, 16, width of the window counter
TimeoutCycles, 255, watchdog limit in WAIT_RES; used only when the optional feature is compiled in

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_go  in  1  one-cycle pulse; starts a job when IDLE, ignored otherwise
cfg_windows  in  CountWidth  number of output windows (job consumes cfg_windows+2 samples)
cfg_bias  in  DataWidth  value sent as dataa on each output command
in_valid  in  1  stream word valid
in_data  in  DataWidth  stream word (3 weights first, then samples)
in_ready  out  1  stream word accepted when in_valid && in_ready
res_valid  out  1  result valid
res_data  out  DataWidth  convolution result
res_ready  in  1  downstream accepts result
pe_reset  out  1  datapath reset/sclr pulse
pe_start  out  1  datapath command strobe
pe_n  out  3  datapath opcode: 0 clr, 1 weight, 2 input, 3 output, 4 get-result
pe_dataa  out  DataWidth  datapath operand
pe_done  in  1  datapath completion
pe_result  in  DataWidth  datapath result
busy  out  1  high whenever state != IDLE
err  out  1  sticky timeout flag; present only with the optional feature

Behaviour:
- Reset: state IDLE; all outputs 0; window buffer, counters and res_data cleared. Reset mid-job aborts immediately, with no pe_reset pulse.
- Every command is a one-cycle pe_start with pe_n/pe_dataa. The command counts as issued only when pe_done=1 in that cycle; otherwise hold it unchanged next cycle.
- IDLE: on cfg_go, latch cfg_windows/cfg_bias, go to CLR. If cfg_windows==0, stay IDLE.
- CLR: pe_reset=1 for exactly 1 cycle, together with start n=0. This zeroes the PE kernel/input address counters and the accumulator. Go to LDW.
- LDW: in_ready=1. Each accepted word is issued the same cycle as n=1, dataa=in_data (combinational pass-through; in_ready is gated by pe_done). After 3 issued, go to FILL.
- FILL: accept 3 samples into window buffer w[0..2], oldest first. No PE commands. Then go to LDI.
- LDI: issue n=2 with w[0], w[1], w[2] over 3 consecutive cycles. The PE input address wraps so that w[k] lands in PE k. Then go to OUT.
- OUT: issue n=3, dataa=cfg_bias. Go to WAIT_RES.
- WAIT_RES: pe_start=0, pe_n=4 held. On pe_done, latch pe_result into res_data and go to EMIT.
- EMIT: res_valid=1 until res_ready; the transfer happens on the cycle both are high. Then decrement the window counter.
  - Counter reaches 0: go to IDLE.
  - Otherwise go to SHIFT.
- SHIFT: in_ready=1. On accept, w[0]<=w[1], w[1]<=w[2], w[2]<=in_data, then go to LDI. Stalls indefinitely while in_valid=0.
- in_ready is 0 in all states other than LDW, FILL and SHIFT. Words offered at other times are not consumed.
- res_valid never drops before handshake; res_data stable while res_valid=1.
- cfg_go while busy: ignored.
- Arithmetic: none in this block; widths pass through unchanged.

Optional Feature:
Macro PE_SEQ_TIMEOUT_EN.
- Defined: an 8-bit+ cycle counter runs in WAIT_RES. When it reaches TimeoutCycles without pe_done:
  - set err (sticky until reset or next cfg_go);
  - pulse pe_reset for 1 cycle;
  - go to IDLE with no result emitted.
- Not defined: WAIT_RES waits indefinitely, err port absent, TimeoutCycles unused.

Decomposition:
- Shared package: state enum (IDLE, CLR, LDW, FILL, LDI, OUT, WAIT_RES, EMIT, SHIFT) and opcode constants OP_CLR=0, OP_W=1, OP_I=2, OP_O=3, OP_GET=4.
- One natural sub-module: pe_seq_window_buf, the 3-entry shift register with load/shift enables and 2-bit fill/issue index.

Test Plan:
- Weights 1,2,3; samples 1..5; windows=3; bias=0; res_ready=1 → results 14, 20, 26 in order; busy low after last EMIT.
- Same job with bias=10 → 24, 30, 36.
- res_ready held 0 for 20 cycles on first result → res_valid stays high with res_data=14 stable; no SHIFT/LDI commands issued meanwhile.
- in_valid gapped (1 of every 4 cycles) → identical results. in_ready only in LDW/FILL/SHIFT. Exactly 3+windows+2 words consumed.
- pe_done forced 0 for 5 cycles during the second LDI command → command held constant, no double issue, results unchanged.
- Reset asserted during WAIT_RES → next cycle IDLE, all outputs 0. With PE_SEQ_TIMEOUT_EN and pe_done stuck 0: err=1 and one pe_reset pulse after TimeoutCycles.

Source files
------------

// File: rtl/pe_column_sequencer_pkg.sv
// Shared types for the PE column command sequencer.
// Holds the sequencer state enum and the datapath opcode constants.
package pe_column_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        LDW,
        FILL,
        LDI,
        OUT,
        WAIT_RES,
        EMIT,
        SHIFT
    } state_t;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_W   = 3'd1;
    localparam logic [2:0] OP_I   = 3'd2;
    localparam logic [2:0] OP_O   = 3'd3;
    localparam logic [2:0] OP_GET = 3'd4;

endpackage

// File: rtl/pe_column_sequencer_window_buf.sv
// 3-entry sample window for the PE column sequencer, plus its 2-bit
// fill/issue index.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_idx_clr    return index to 0 (wins over i_step)
//   i_step       advance index by one
//   i_load       write i_data into w[index]
//   i_shift      w0<=w1, w1<=w2, w2<=i_data
//   i_data       incoming sample
//   o_idx        current index
//   o_word       w[index]
module pe_seq_window_buf #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_idx_clr,
    input  logic                 i_step,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [DataWidth-1:0] i_data,
    output logic [1:0]           o_idx,
    output logic [DataWidth-1:0] o_word
);

    logic [DataWidth-1:0] r_w0;
    logic [DataWidth-1:0] r_w1;
    logic [DataWidth-1:0] r_w2;
    logic [1:0]           r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_w0  <= '0;
            r_w1  <= '0;
            r_w2  <= '0;
        end else begin
            if (i_idx_clr) begin
                r_idx <= '0;
            end else if (i_step) begin
                r_idx <= r_idx + 2'd1;
            end
            if (i_shift) begin
                r_w0 <= r_w1;
                r_w1 <= r_w2;
                r_w2 <= i_data;
            end else if (i_load) begin
                case (r_idx)
                    2'd0:    r_w0 <= i_data;
                    2'd1:    r_w1 <= i_data;
                    default: r_w2 <= i_data;
                endcase
            end
        end
    end

    always_comb begin
        case (r_idx)
            2'd0:    o_word = r_w0;
            2'd1:    o_word = r_w1;
            default: o_word = r_w2;
        endcase
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/pe_column_sequencer.sv
// Autonomous command sequencer for the 3-PE column + accumulator datapath:
// loads 3 weights, then runs a stride-1 3-tap convolution over the sample
// stream, returning one result per window on a valid/ready stream.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cfg_go/cfg_windows/cfg_bias      job start pulse and job parameters
//   in_valid/in_data/in_ready        word stream (3 weights, then samples)
//   res_valid/res_data/res_ready     result stream
//   pe_reset/pe_start/pe_n/pe_dataa  datapath command port
//   pe_done/pe_result                datapath completion and result
//   busy                             high whenever not IDLE
//   err                              sticky WAIT_RES timeout flag
// Optional macro PE_SEQ_TIMEOUT_EN adds the WAIT_RES watchdog and err port.
module pe_column_sequencer
    import pe_column_sequencer_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int CountWidth    = 16,
    parameter int TimeoutCycles = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_go,
    input  logic [CountWidth-1:0] cfg_windows,
    input  logic [DataWidth-1:0]  cfg_bias,
    input  logic                  in_valid,
    input  logic [DataWidth-1:0]  in_data,
    output logic                  in_ready,
    output logic                  res_valid,
    output logic [DataWidth-1:0]  res_data,
    input  logic                  res_ready,
    output logic                  pe_reset,
    output logic                  pe_start,
    output logic [2:0]            pe_n,
    output logic [DataWidth-1:0]  pe_dataa,
    input  logic                  pe_done,
    input  logic [DataWidth-1:0]  pe_result,
    output logic                  busy
`ifdef PE_SEQ_TIMEOUT_EN
    ,
    output logic                  err
`endif
);

    state_t                r_state;
    state_t                w_next;
    logic [CountWidth-1:0] r_cnt;
    logic [DataWidth-1:0]  r_bias;
    logic [DataWidth-1:0]  r_res;
    logic                  r_clr_sent;

    logic                  w_latch;
    logic                  w_res_en;
    logic                  w_dec;
    logic                  w_idx_clr;
    logic                  w_step;
    logic                  w_load;
    logic                  w_shift;
    logic [1:0]            w_idx;
    logic [DataWidth-1:0]  w_word;
    logic                  w_last;
    logic                  w_tmo_fire;

    pe_seq_window_buf #(
        .DataWidth(DataWidth)
    ) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .i_idx_clr(w_idx_clr),
        .i_step   (w_step),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (in_data),
        .o_idx    (w_idx),
        .o_word   (w_word)
    );

    assign w_last = (w_idx == 2'd2);

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TmoW =
        (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;

    logic [TmoW-1:0] r_tmo;
    logic            r_err;
    logic            w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TmoW'(TimeoutCycles - 1));
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (r_state == WAIT_RES) ? r_tmo + 1'b1 : '0;
            if (r_state == IDLE && cfg_go) begin
                r_err <= 1'b0;
            end else if (w_tmo_fire) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TimeoutCycles != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bias     <= '0;
            r_res      <= '0;
            r_clr_sent <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_clr_sent <= (r_state == CLR);
            if (w_latch) begin
                r_cnt  <= cfg_windows;
                r_bias <= cfg_bias;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_res_en) begin
                r_res <= pe_result;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        pe_reset   = 1'b0;
        pe_start   = 1'b0;
        pe_n       = OP_CLR;
        pe_dataa   = '0;
        w_latch    = 1'b0;
        w_res_en   = 1'b0;
        w_dec      = 1'b0;
        w_idx_clr  = 1'b0;
        w_step     = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_tmo_fire = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_idx_clr = 1'b1;
                if (cfg_go && cfg_windows != '0) begin
                    w_latch = 1'b1;
                    w_next  = CLR;
                end
            end
            CLR: begin
                // sclr only on the first cycle even if the clr is held
                pe_reset = !r_clr_sent;
                pe_start = 1'b1;
                if (pe_done) w_next = LDW;
            end
            LDW: begin
                // weight goes straight through; accept only when issued
                pe_n     = OP_W;
                pe_dataa = in_data;
                pe_start = in_valid;
                in_ready = pe_done;
                if (in_valid && pe_done) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_idx_clr = 1'b1;
                        w_next    = FILL;
                    end
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_step = 1'b1;
                    if (w_last) begin
                        w_idx_clr = 1'b1;
                        w_next    = LDI;
                    end
                end
            end
            LDI: begin
                pe_start = 1'b1;
                pe_n     = OP_I;
                pe_dataa = w_word;
                if (pe_done) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_idx_clr = 1'b1;
                        w_next    = OUT;
                    end
                end
            end
            OUT: begin
                pe_start = 1'b1;
                pe_n     = OP_O;
                pe_dataa = r_bias;
                if (pe_done) w_next = WAIT_RES;
            end
            WAIT_RES: begin
                pe_n = OP_GET;
                if (pe_done) begin
                    w_res_en = 1'b1;
                    w_next   = EMIT;
                end
`ifdef PE_SEQ_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    pe_reset   = 1'b1;
                    w_tmo_fire = 1'b1;
                    w_next     = IDLE;
                end
`endif
            end
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_dec  = 1'b1;
                    w_next = (r_cnt == CountWidth'(1)) ? IDLE : SHIFT;
                end
            end
            SHIFT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_shift = 1'b1;
                    w_next  = LDI;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign res_data = r_res;

endmodule

// File: tb/tb_pe_column_sequencer.sv
// Self-checking bench for pe_column_sequencer: table-driven jobs, random
// jobs against a convolution reference, reset-abort and timeout sequences.
module tb_pe_column_sequencer;

    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int TMO  = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_go;
    logic [CW-1:0] cfg_windows;
    logic [DW-1:0] cfg_bias;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          pe_reset;
    logic          pe_start;
    logic [2:0]    pe_n;
    logic [DW-1:0] pe_dataa;
    logic          pe_done;
    logic [DW-1:0] pe_result;
    logic          busy;
`ifdef PE_SEQ_TIMEOUT_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    pe_column_sequencer #(
        .DataWidth    (DW),
        .CountWidth   (CW),
        .TimeoutCycles(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_go     (cfg_go),
        .cfg_windows(cfg_windows),
        .cfg_bias   (cfg_bias),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .pe_reset   (pe_reset),
        .pe_start   (pe_start),
        .pe_n       (pe_n),
        .pe_dataa   (pe_dataa),
        .pe_done    (pe_done),
        .pe_result  (pe_result),
        .busy       (busy)
`ifdef PE_SEQ_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode: 0 normal job, 1 reset in WAIT_RES, 2 pe_done stuck (timeout)
    typedef struct packed {
        logic [2:0][31:0] w;
        logic [7:0][31:0] s;
        logic [5:0][31:0] exp;
        logic [31:0]      bias;
        logic [3:0]       nwin;
        logic [3:0]       gap;
        logic [7:0]       rr_hold;
        logic [3:0]       done_stall;
        logic [1:0]       mode;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] bias,
                                input logic [7:0] rr, input logic [3:0] gap,
                                input logic [3:0] stall,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v = '0;
        v.w[0] = 1; v.w[1] = 2; v.w[2] = 3;
        for (int i = 0; i < 5; i++) v.s[i] = 32'(i + 1);
        v.nwin = 3;
        v.bias = bias;
        v.rr_hold = rr;
        v.gap = gap;
        v.done_stall = stall;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        return v;
    endfunction

    // Convolution reference: out[i] = sum_k w[k]*s[i+k] + bias
    function automatic logic [31:0] ref_win(input vec_t v, input int i);
        logic [31:0] acc;
        acc = v.bias;
        for (int k = 0; k < 3; k++) acc += v.w[k] * v.s[i + k];
        return acc;
    endfunction

    function automatic logic [31:0] word_at(input vec_t v, input int p);
        return (p < 3) ? v.w[p] : v.s[p - 3];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_pe_reset"}, 32'(pe_reset), 0);
        check({tag, "_pe_start"}, 32'(pe_start), 0);
        check({tag, "_pe_n"}, 32'(pe_n), 0);
        check({tag, "_pe_dataa"}, pe_dataa, 0);
    endtask

    task automatic run_job(input vec_t v);
        int          nwords;
        int          ptr;
        int          k;
        int          cyc;
        int          hold;
        int          stall;
        int          ldi_iss;
        int          wait_cyc;
        int          gap;
        bit          acc;
        bit          fin;
        bit          aborted;
        logic [31:0] held_d;
        logic [31:0] pw [3];
        logic [31:0] px [3];
        int          pwi;
        int          pxi;
        logic [31:0] pres;

        nwords = 5 + int'(v.nwin);
        ptr = 0; k = 0; cyc = 0; ldi_iss = 0; wait_cyc = 0;
        hold = int'(v.rr_hold);
        stall = int'(v.done_stall);
        gap = (v.gap == 0) ? 1 : int'(v.gap);
        acc = 0; fin = 0; aborted = 0; held_d = '0;
        pwi = 0; pxi = 0; pres = '0;
        for (int i = 0; i < 3; i++) begin
            pw[i] = '0;
            px[i] = '0;
        end

        @(negedge clk);
        cfg_go = 1'b1;
        cfg_windows = CW'(v.nwin);
        cfg_bias = v.bias;
        @(negedge clk);

        while (!fin && cyc < 3000) begin
            cfg_go = (cyc == 7);
            if (cyc == 7) begin
                cfg_windows = 7;
                cfg_bias = 999;
            end
            if (acc) in_valid = 1'b0;
            acc = 0;
            if (!in_valid && ptr < nwords && (cyc % gap) == 0) begin
                in_valid = 1'b1;
                in_data = word_at(v, ptr);
            end
            res_ready = (hold == 0);
            pe_done = 1'b1;
            #1;
            if (busy && pe_start && pe_n == 3'd2 && ldi_iss == 1 &&
                stall > 0) begin
                if (stall == int'(v.done_stall)) held_d = pe_dataa;
                else check("held_cmd", pe_dataa, held_d);
                pe_done = 1'b0;
                stall--;
                #1;
            end
            if (v.mode != 0 && busy && !pe_start && pe_n == 3'd4) begin
                pe_done = 1'b0;
                #1;
                if (v.mode == 1) begin
                    reset = 1'b1;
                    in_valid = 1'b0;
                    @(negedge clk);
                    check_idle_outputs("abort");
                    reset = 1'b0;
                    aborted = 1;
                    fin = 1;
                    continue;
                end
                wait_cyc++;
                if (pe_reset) begin
                    check("timeout_cycles", wait_cyc, TMO);
                    @(negedge clk);
`ifdef PE_SEQ_TIMEOUT_EN
                    check("timeout_err", 32'(err), 1);
`endif
                    check("timeout_busy", 32'(busy), 0);
                    check("timeout_pe_reset_once", 32'(pe_reset), 0);
                    check("timeout_no_result", 32'(res_valid), 0);
                    aborted = 1;
                    fin = 1;
                    continue;
                end
            end
            if (!busy || res_valid || pe_n == 3'd4 ||
                (pe_start && (pe_n == 3'd2 || pe_n == 3'd3)))
                check("in_ready_gate", 32'(in_ready), 0);
            if (res_valid && !res_ready) begin
                check("res_stable", res_data, v.exp[k]);
                check("no_cmd_in_emit", 32'(pe_start), 0);
                hold--;
            end
            if (in_valid && in_ready) begin
                ptr++;
                acc = 1;
            end
            if (res_valid && res_ready) begin
                check("result", res_data, v.exp[k]);
                k++;
            end
            if (pe_reset) begin
                pwi = 0;
                pxi = 0;
            end
            if (pe_start && pe_done) begin
                case (pe_n)
                    3'd0: begin
                        pwi = 0;
                        pxi = 0;
                    end
                    3'd1: begin
                        pw[pwi % 3] = pe_dataa;
                        pwi++;
                    end
                    3'd2: begin
                        if (ldi_iss == 1 && v.done_stall != 0)
                            check("held_issue", pe_dataa, held_d);
                        px[pxi] = pe_dataa;
                        pxi = (pxi + 1) % 3;
                        ldi_iss++;
                    end
                    3'd3: pres = pw[0] * px[0] + pw[1] * px[1] +
                                 pw[2] * px[2] + pe_dataa;
                    default: ;
                endcase
            end
            pe_result = pres;
            @(negedge clk);
            cyc++;
            if (k == int'(v.nwin)) begin
                check("busy_after_last", 32'(busy), 0);
                fin = 1;
            end
        end
        in_valid = 1'b0;
        pe_done = 1'b1;
        res_ready = 1'b1;
        cfg_go = 1'b0;
        if (!fin) check("job_timeout", 0, 1);
        if (!aborted && fin) begin
            check("words_consumed", ptr, nwords);
            check("ldi_issues", ldi_iss, 3 * int'(v.nwin));
            in_valid = 1'b1;
            in_data = 32'hdead;
            #1;
            check("idle_no_accept", 32'(in_ready), 0);
            @(negedge clk);
            check("idle_no_accept2", 32'(in_ready), 0);
            in_valid = 1'b0;
        end
    endtask

    vec_t tbl [5];
    vec_t v;

    initial begin
        reset = 1'b1;
        cfg_go = 1'b0;
        cfg_windows = '0;
        cfg_bias = '0;
        in_valid = 1'b0;
        in_data = '0;
        res_ready = 1'b1;
        pe_done = 1'b1;
        pe_result = '0;

        tbl[0] = mk(0, 0, 1, 0, 14, 20, 26);
        tbl[1] = mk(10, 0, 1, 0, 24, 30, 36);
        tbl[2] = mk(0, 20, 1, 0, 14, 20, 26);
        tbl[3] = mk(0, 0, 4, 0, 14, 20, 26);
        tbl[4] = mk(0, 0, 1, 5, 14, 20, 26);

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
`ifdef PE_SEQ_TIMEOUT_EN
        check("reset_err", 32'(err), 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        cfg_go = 1'b1;
        cfg_windows = '0;
        @(negedge clk);
        cfg_go = 1'b0;
        check("zero_windows_busy", 32'(busy), 0);
        check("zero_windows_pe_reset", 32'(pe_reset), 0);

        for (int t = 0; t < 5; t++) run_job(tbl[t]);

        v = tbl[0];
        v.mode = 1;
        run_job(v);

        for (int r = 0; r < 6; r++) begin
            v = '0;
            v.nwin = 4'($urandom_range(1, 6));
            for (int i = 0; i < 3; i++) v.w[i] = $urandom_range(0, 255);
            for (int i = 0; i < 8; i++) v.s[i] = $urandom_range(0, 255);
            v.bias = $urandom;
            v.gap = 4'($urandom_range(1, 3));
            v.rr_hold = 8'($urandom_range(0, 3));
            v.done_stall = 4'($urandom_range(0, 3));
            for (int i = 0; i < int'(v.nwin); i++) v.exp[i] = ref_win(v, i);
            run_job(v);
        end

`ifdef PE_SEQ_TIMEOUT_EN
        v = tbl[1];
        v.mode = 2;
        run_job(v);
        run_job(tbl[0]);
        check("err_cleared_by_go", 32'(err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
